// File: rtl/grant_decoder_pkg.sv
// Shared types, defaults and helpers for the grant decoder.
package grant_decoder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int unsigned DEF_IDX_W    = 2;
  localparam int unsigned DEF_N        = 4;
  localparam int unsigned DEF_HOLD_MAX = 15;

  // Wide result; callers size-cast to their grant width.
  function automatic logic [31:0] onehot(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/grant_hold_timer.sv
// Loadable saturating hold counter; tc flags that the count has reached HOLD_MAX.
module grant_hold_timer #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = $clog2(HOLD_MAX + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(1);
    end else if (en && !tc) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tc = (cnt_q == CW'(HOLD_MAX));

endmodule

// File: rtl/grant_decoder.sv
// Registers an accepted index and holds a one-hot grant until release or hold timeout.
// Define GRANT_DECODER_B2B_EN to allow a new grant on the release edge with no idle bubble.
module grant_decoder
  import grant_decoder_pkg::*;
#(
  parameter int unsigned IDX_W    = DEF_IDX_W,
  parameter int unsigned N        = DEF_N,
  parameter int unsigned HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] code_in,
  input  logic             code_valid,
  output logic             code_ready,
  input  logic [N-1:0]     release_in,
  output logic [N-1:0]     grant,
  output logic             busy,
  output logic             timeout
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     grant_q, grant_d;
  logic             timeout_q, timeout_d;
  logic             tmr_load, tmr_clear, tmr_en, tmr_tc;
  logic             rel;

  assign rel = release_in[idx_q];

  grant_hold_timer #(
    .HOLD_MAX(HOLD_MAX)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .clear(tmr_clear),
    .en   (tmr_en),
    .tc   (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    grant_d    = grant_q;
    timeout_d  = 1'b0;
    tmr_load   = 1'b0;
    tmr_clear  = 1'b0;
    tmr_en     = 1'b0;
    code_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        code_ready = 1'b1;
        if (code_valid) begin
          idx_d    = code_in;
          grant_d  = N'(onehot(32'(code_in)));
          tmr_load = 1'b1;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
`ifdef GRANT_DECODER_B2B_EN
        code_ready = rel;
`endif
        if (rel) begin
          // Release beats a coincident timeout.
          if (code_ready && code_valid) begin
            idx_d    = code_in;
            grant_d  = N'(onehot(32'(code_in)));
            tmr_load = 1'b1;
          end else begin
            grant_d   = '0;
            tmr_clear = 1'b1;
            state_d   = ST_IDLE;
          end
        end else if (tmr_tc) begin
          grant_d   = '0;
          tmr_clear = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q == ST_GRANT);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_grant_decoder.sv
// Directed, table-driven bench for grant_decoder plus hand-written multi-cycle sequences.
module tb_grant_decoder;

`ifdef GRANT_DECODER_B2B_EN
  localparam logic B2B = 1'b1;
`else
  localparam logic B2B = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] code_in;
  logic       code_valid;
  logic       code_ready;
  logic [3:0] release_in;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  int nvec;
  int nfail;

  grant_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .code_in   (code_in),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .release_in(release_in),
    .grant     (grant),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       cv;
    logic [1:0] ci;
    logic [3:0] rel;
    logic       ready;
    logic [3:0] grant;
    logic       busy;
    logic       to;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int hi, to_cnt, to_at, bad;

  initial begin
    nvec = 0;
    nfail = 0;
    rst = 1'b1;
    code_in = '0;
    code_valid = 1'b0;
    release_in = '0;

    //          cv    ci     rel      ready  grant    busy  to
    vecs[0]  = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'd2, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 4'b0100, B2B,  4'b0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 2'd1, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 2'd3, 4'b1101, 1'b0, 4'b0010, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 2'd0, 4'b1101, 1'b0, 4'b0010, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 2'd0, 4'b1101, 1'b0, 4'b0010, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 4'b1101, 1'b0, 4'b0010, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 2'd0, 4'b1101, 1'b0, 4'b0010, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 2'd0, 4'b0010, B2B,  4'b0000, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.grant", 32'(grant), 32'h0);
    check("reset.busy", 32'(busy), 32'h0);
    check("reset.timeout", 32'(timeout), 32'h0);
    check("reset.ready", 32'(code_ready), 32'h1);

    // Table: basic accept/release and ignored wrong-bit releases.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      code_valid = vecs[i].cv;
      code_in    = vecs[i].ci;
      release_in = vecs[i].rel;
      #1;
      check($sformatf("vec%0d.ready", i), 32'(code_ready), 32'(vecs[i].ready));
      tick();
      check($sformatf("vec%0d.grant", i), 32'(grant), 32'(vecs[i].grant));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d.timeout", i), 32'(timeout), 32'(vecs[i].to));
    end
    release_in = '0;
    code_valid = 1'b0;

    // Timeout: index 3, no release; grant for exactly 15 cycles then a 1-cycle timeout.
    @(negedge clk);
    code_valid = 1'b1;
    code_in    = 2'd3;
    tick();
    code_valid = 1'b0;
    hi = 0; to_cnt = 0; to_at = -1; bad = 0;
    for (int k = 0; k < 25; k++) begin
      if (grant == 4'b1000) hi++;
      else if (grant != 4'b0000) bad++;
      if (timeout) begin
        to_cnt++;
        to_at = k;
      end
      tick();
    end
    check("timeout.grant_cycles", 32'(hi), 32'd15);
    check("timeout.bad_grant", 32'(bad), 32'd0);
    check("timeout.pulse_count", 32'(to_cnt), 32'd1);
    check("timeout.pulse_pos", 32'(to_at), 32'd15);

    // Release on the timeout edge: release wins, no timeout pulse.
    @(negedge clk);
    code_valid = 1'b1;
    code_in    = 2'd0;
    tick();
    code_valid = 1'b0;
    hi = 0;
    for (int k = 0; k < 14; k++) begin
      if (grant == 4'b0001) hi++;
      tick();
    end
    check("relto.held", 32'(hi), 32'd14);
    check("relto.last_cycle_grant", 32'(grant), 32'h1);
    release_in = 4'b0001;
    tick();
    release_in = '0;
    check("relto.grant", 32'(grant), 32'h0);
    check("relto.timeout", 32'(timeout), 32'h0);
    tick();
    check("relto.timeout_next", 32'(timeout), 32'h0);

    // Back-to-back with code_valid held high.
    @(negedge clk);
    code_valid = 1'b1;
    code_in    = 2'd1;
    tick();
    check("b2b.first_grant", 32'(grant), 32'h2);
    code_in    = 2'd0;
    release_in = 4'b0010;
    tick();
    release_in = '0;
    check("b2b.second_grant", 32'(grant), B2B ? 32'h1 : 32'h0);
    check("b2b.second_busy", 32'(busy), B2B ? 32'h1 : 32'h0);
    tick();
    check("b2b.third_grant", 32'(grant), 32'h1);
    check("b2b.third_busy", 32'(busy), 32'h1);
    code_valid = 1'b0;
    release_in = 4'b0001;
    tick();
    release_in = '0;
    check("b2b.drop", 32'(grant), 32'h0);

    // Asynchronous reset in the middle of a grant.
    @(negedge clk);
    code_valid = 1'b1;
    code_in    = 2'd2;
    tick();
    code_valid = 1'b0;
    check("rstmid.pre_grant", 32'(grant), 32'h4);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid.grant", 32'(grant), 32'h0);
    check("rstmid.busy", 32'(busy), 32'h0);
    check("rstmid.timeout", 32'(timeout), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid.ready", 32'(code_ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/grant_decoder.md
Name: grant_decoder

Overview:
- Receiving end of the 4-input priority encoder's (code, valid) output.
- Registers an accepted 2-bit index and drives a one-hot grant line to the selected requester.
- Holds the grant until that requester releases it, or until a hold timeout expires.
- Sits between the request encoder and the granted resource users; only one grant is ever outstanding.

Parameters:
- IDX_W, 2, width of incoming index code.
- N, 4, number of grant lines; must equal 2**IDX_W.
- HOLD_MAX, 15, maximum number of cycles a grant may stay high without release; legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- code_in  input  IDX_W  index of the requester to grant (encoder out).
- code_valid  input  1  code_in is meaningful (encoder valid).
- code_ready  output  1  block can accept a code this cycle.
- release_in  input  N  per-requester done strobe; only the bit of the current grant is honoured.
- grant  output  N  registered one-hot grant; all zero when idle.
- busy  output  1  a grant is outstanding.
- timeout  output  1  one-cycle pulse when a grant is force-dropped.

Behaviour:
- Reset (async, immediate, including mid-grant): state=IDLE, grant=0, busy=0, timeout=0, hold counter=0, captured index=0.
- code_ready is combinational from state: 1 in IDLE, 0 in GRANT (see optional feature).
- IDLE:
  - On a rising edge with code_valid && code_ready: capture code_in, set grant = 1<<code_in, set busy=1, load counter=1, go to GRANT.
  - Latency: grant is visible in the cycle after acceptance.
  - code_valid low: stay in IDLE; grant stays 0.
- GRANT:
  - grant and the captured index are held stable; code_in and code_valid are ignored.
  - release_in[idx]=1 at an edge: grant=0, busy=0, counter=0, go to IDLE.
  - release_in bits other than idx are ignored, including multiple bits set at once.
  - No release and counter==HOLD_MAX at an edge: grant=0, busy=0, timeout=1 for exactly one cycle, go to IDLE.
  - Result: grant is high for at most HOLD_MAX cycles.
  - Otherwise the counter increments.
- Simultaneous release and timeout at the same edge: release wins and timeout stays 0.
- timeout clears on the following edge regardless of state.
- Counter width is $clog2(HOLD_MAX+1). The counter saturates and never wraps, because the timeout always fires first.
- Without the optional feature there is one mandatory IDLE cycle (code_ready=1) between grants.
- grant is never multi-hot and never changes except on the IDLE→GRANT and GRANT→IDLE edges.

Optional Feature:
- Macro: GRANT_DECODER_B2B_EN.
- Defined:
  - In GRANT, code_ready = release_in[idx].
  - If code_valid is also high at that edge, the new index is captured and grant switches directly from the old one-hot to the new one. State stays GRANT, counter reloads to 1, busy stays 1.
  - This gives zero-bubble back-to-back grants. A timeout edge never accepts a new code.
- Undefined: behaviour exactly as above, with one idle cycle between grants.

Decomposition:
- Shared package grant_decoder_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1;
  - default IDX_W/N/HOLD_MAX constants;
  - a helper function onehot(idx) returning 1<<idx.
- One natural sub-module, grant_hold_timer: a loadable saturating counter with a load input, enable, and a terminal-count flag at HOLD_MAX. The top level keeps the FSM and the grant register.

Test Plan:
- Reset mid-grant: with grant=4'b0100, assert rst between clock edges → grant=0, busy=0, timeout=0 immediately; after rst drops, code_ready=1.
- Basic accept/release: code_in=2'd2, code_valid=1 for one cycle → next cycle grant=4'b0100, busy=1. Pulse release_in=4'b0100 three cycles later → grant=0 next cycle; code_ready=1.
- Wrong release ignored: grant=4'b0010; drive release_in=4'b1101 for 5 cycles → grant held at 4'b0010, timeout=0.
- Timeout with HOLD_MAX=15: grant index 3, no release → grant=4'b1000 for exactly 15 cycles, then 0, with timeout high for 1 cycle.
- Release on the timeout edge: release_in[idx]=1 in the 15th grant cycle → grant drops, timeout stays 0.
- Back-to-back:
  - Hold code_valid=1 throughout: code_in=1, then code_in=0 presented with the release.
  - Without the macro: grant sequence 0010 → 0000 (one cycle) → 0001.
  - With GRANT_DECODER_B2B_EN: grant sequence 0010 → 0001 with no zero cycle, busy stays 1.
